// File: rtl/fd_ibuf_pkg.sv
// fd_ibuf_pkg: shared types for the fetch/decode instruction buffer.
//   ibus_req_t / ibus_resp_t : instruction bus request and response
//   fd_ibuf_state_t          : buffer FSM states
//   fd_slot_t                : one decode slot (instr, pc, evector, valid)
//   NOP_INSTR_DEFAULT        : default bubble/exception instruction word
package fd_ibuf_pkg;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   // evector bit flagging a misaligned fetch PC
   localparam int unsigned EV_MISALIGN = 1;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } fd_ibuf_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [7:0]  evector;
      logic        valid;
   } fd_slot_t;

   function automatic fd_slot_t make_slot(input logic [31:0] instr,
                                          input logic [31:0] pc,
                                          input logic [7:0]  evector);
      fd_slot_t s;
      s.instr   = instr;
      s.pc      = pc;
      s.evector = evector;
      s.valid   = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/fd_ibuf_if.sv
// fd_ibuf_if: instruction bus between the fetch buffer and the memory side.
//   ireq  : request (valid, addr), driven by the buffer (master)
//   iresp : response (addr_ok, data_ok, data), driven by the bus (slave)
interface fd_ibuf_if;
   import fd_ibuf_pkg::*;

   ibus_req_t  ireq;
   ibus_resp_t iresp;

   modport master (output ireq, input iresp);
   modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fd_ibuf_slot_reg.sv
// fd_slot_reg: fetch/decode pipeline register.
//   clk, reset : clock, synchronous active-high reset
//   flush      : kill slot (valid=0, instr=NOP, evector=0)
//   stall      : hold current contents
//   load       : slot_in carries a delivered instruction; otherwise a bubble
//   slot_in    : incoming slot
//   slot_q     : registered slot presented to decode
module fd_slot_reg
   import fd_ibuf_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   input  logic     stall,
   input  logic     load,
   input  fd_slot_t slot_in,
   output fd_slot_t slot_q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q.instr   <= NOP_INSTR;
         slot_q.pc      <= '0;
         slot_q.evector <= '0;
         slot_q.valid   <= 1'b0;
      end else if (flush) begin
         slot_q.instr   <= NOP_INSTR;
         slot_q.evector <= '0;
         slot_q.valid   <= 1'b0;
      end else if (!stall) begin
         if (load) begin
            slot_q <= slot_in;
         end else begin
            // bubble: pc is kept, it has no meaning while valid=0
            slot_q.instr   <= NOP_INSTR;
            slot_q.evector <= '0;
            slot_q.valid   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fd_ibuf.sv
// fd_ibuf: instruction-bus response buffer + fetch/decode pipeline register.
//   clk, reset       : clock, synchronous active-high reset
//   pc_f, evector_f  : PC and exception vector from fetch (bit1 = misaligned)
//   ibus             : instruction bus (master side: ireq out, iresp in)
//   advance_f        : one-cycle pulse, fetch loads its next PC
//   stall_d, flush_d : decode back-pressure and kill
//   instr_d, pc_d, evector_d, valid_d : registered decode slot
//   stat_wait_cycles : only with FD_IBUF_STAT_EN, cycles spent requesting,
//                      waiting or dropping
module fd_ibuf
   import fd_ibuf_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_f,
   input  logic [7:0]  evector_f,
   fd_ibuf_if.master   ibus,
   output logic        advance_f,
   input  logic        stall_d,
   input  logic        flush_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [7:0]  evector_d,
   output logic        valid_d
`ifdef FD_IBUF_STAT_EN
   ,
   output logic [31:0] stat_wait_cycles
`endif
);

   fd_ibuf_state_t state, state_nx;
   fd_slot_t       hold_q, cand, slot_q;
   logic [31:0]    req_pc;
   logic [7:0]     req_ev;
   logic           req_valid, deliver, hold_load, misalign;
   ibus_resp_t     resp;

   assign resp     = ibus.iresp;
   assign misalign = evector_f[EV_MISALIGN];

   always_comb begin
      state_nx  = state;
      req_valid = 1'b0;
      deliver   = 1'b0;
      hold_load = 1'b0;
      cand      = make_slot(resp.data, req_pc, req_ev);
      case (state)
         ST_REQ: begin
            cand = make_slot(misalign ? NOP_INSTR : resp.data, pc_f, evector_f);
            if (misalign) begin
               // exception slot: no bus traffic, fetch still advances
               deliver = !flush_d && !stall_d;
            end else begin
               req_valid = 1'b1;
               if (resp.addr_ok) begin
                  if (flush_d)
                     state_nx = resp.data_ok ? ST_REQ : ST_DROP;
                  else if (!resp.data_ok)
                     state_nx = ST_WAIT;
                  else if (stall_d) begin
                     hold_load = 1'b1;
                     state_nx  = ST_HOLD;
                  end else
                     deliver = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (resp.data_ok) begin
               if (flush_d)
                  state_nx = ST_REQ;
               else if (stall_d) begin
                  hold_load = 1'b1;
                  state_nx  = ST_HOLD;
               end else begin
                  deliver  = 1'b1;
                  state_nx = ST_REQ;
               end
            end else if (flush_d)
               state_nx = ST_DROP;
         end
         ST_HOLD: begin
            cand = hold_q;
            if (flush_d)
               state_nx = ST_REQ;
            else if (!stall_d) begin
               deliver  = 1'b1;
               state_nx = ST_REQ;
            end
         end
         ST_DROP: begin
            if (resp.data_ok)
               state_nx = ST_REQ;
         end
         default: state_nx = ST_REQ;
      endcase
      // nothing leaves the block while it is being reset
      if (reset) begin
         req_valid = 1'b0;
         deliver   = 1'b0;
      end
   end

   assign ibus.ireq.valid = req_valid;
   assign ibus.ireq.addr  = pc_f;
   assign advance_f       = deliver;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_REQ;
         hold_q <= '0;
         req_pc <= '0;
         req_ev <= '0;
      end else begin
         state <= state_nx;
         if (hold_load)
            hold_q <= cand;
         // remember the accepted request so a late response keeps its PC
         // even if fetch is redirected meanwhile
         if (req_valid && resp.addr_ok) begin
            req_pc <= pc_f;
            req_ev <= evector_f;
         end
      end
   end

   fd_slot_reg #(.NOP_INSTR(NOP_INSTR)) u_slot_reg (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush_d),
      .stall   (stall_d),
      .load    (deliver),
      .slot_in (cand),
      .slot_q  (slot_q)
   );

   assign instr_d   = slot_q.instr;
   assign pc_d      = slot_q.pc;
   assign evector_d = slot_q.evector;
   assign valid_d   = slot_q.valid;

`ifdef FD_IBUF_STAT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stat_wait_cycles <= '0;
      else if ((state == ST_REQ && req_valid) || state == ST_WAIT || state == ST_DROP)
         stat_wait_cycles <= stat_wait_cycles + 32'd1;
   end
`endif

endmodule

// File: doc/fd_ibuf.md
# fd_ibuf

Instruction-bus response buffer and fetch/decode pipeline register, placed between the fetch stage and decode.
- Owns the `ibus` request/response handshake for the PC presented by fetch.
- Holds a returned instruction while decode is stalled and discards responses belonging to flushed fetches.
- Presents a registered instruction, PC and exception vector to decode.
- Tells fetch when to advance its PC.

## Interface
Parameters:
- `NOP_INSTR`, default `32'h0000_0000`: instruction word driven for bubbles and exception slots.

Ports (name, direction, width, meaning):
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pc_f` in 32: PC presented by fetch.
- `evector_f` in 8: fetch exception vector; bit 1 = misaligned PC.
- `ireq` out `ibus_req_t`: `valid`, `addr`.
- `iresp` in `ibus_resp_t`: `addr_ok`, `data_ok`, `data`.
- `advance_f` out 1: one-cycle pulse; fetch loads its next PC.
- `stall_d` in 1: decode cannot accept.
- `flush_d` in 1: kill the in-flight fetch and the decode slot.
- `instr_d` out 32: instruction to decode.
- `pc_d` out 32: PC of `instr_d`.
- `evector_d` out 8: exception vector of `instr_d`.
- `valid_d` out 1: decode slot holds a real instruction.

## Operation
States:
- **REQ**
  - Drive `ireq.valid=1`, `ireq.addr=pc_f`.
  - If `evector_f[1]`: drive `ireq.valid=0` and issue no bus transaction. When `!stall_d`, deliver a slot with `NOP_INSTR`, `pc_f`, `evector_f`; pulse `advance_f`; stay in REQ.
  - `addr_ok` with `data_ok` in the same cycle: treat as a response in WAIT.
  - `addr_ok` without `data_ok`: go to WAIT.
- **WAIT**
  - `ireq.valid=0`; wait for `data_ok`.
  - On `data_ok` with `!stall_d`: load the decode register, pulse `advance_f`, go to REQ.
  - On `data_ok` with `stall_d`: capture `data`/PC into the hold register, go to HOLD.
- **HOLD**
  - Wait for `!stall_d`, then load the decode register from the hold register, pulse `advance_f`, go to REQ.
- **DROP**
  - Reached when a flush hits an accepted-but-unanswered request.
  - On `data_ok`: discard the data, go to REQ. No `advance_f`.

Flush rules (`flush_d` has priority over `stall_d` and over delivery):
- REQ before `addr_ok`: stay in REQ. `ireq.addr` follows the new `pc_f`; this is the only case where the address may change before `addr_ok`.
- REQ with `addr_ok` but no `data_ok`, or WAIT without `data_ok`: go to DROP.
- WAIT with `data_ok` in the same cycle, or HOLD: discard, go to REQ.
- In every state, `advance_f` is suppressed for that cycle.

Handshake and decode register:
- `ireq.valid` and `ireq.addr` stay stable from assertion until `addr_ok`, except for the flush case above.
- At most one outstanding request.
- Decode register update, in priority order:
  - `flush_d`: `valid_d=0`, `instr_d=NOP_INSTR`, `evector_d=0`.
  - else `stall_d`: hold all outputs.
  - else: load the delivered slot if there is one, otherwise insert a bubble (`valid_d=0`).

## Timing
- Reset: state REQ, `valid_d=0`, `instr_d=NOP_INSTR`, `pc_d=0`, `evector_d=0`, `advance_f=0`, hold register cleared. `ireq.valid=1` in the first cycle after `reset` falls.
- `reset` asserted mid-transaction: FSM returns to REQ. A late `data_ok` from the aborted request is not tracked; the bus is reset together with the block.
- Best case, `addr_ok` and `data_ok` in cycle t:
  - `advance_f` at t; `valid_d=1` at t+1; next request at t+1.
  - Throughput is one instruction per cycle.
- `data_ok` k cycles after `addr_ok`: instruction reaches decode one cycle after `data_ok`.
- HOLD release: decode register loads on the first `!stall_d` edge.
- `advance_f` is combinational from state and `iresp`, and is never asserted in the same cycle as `flush_d`.

## Configuration
- `FD_IBUF_STAT_EN` defined: adds output `stat_wait_cycles` (32 bits).
  - Counts cycles spent in REQ (with `ireq.valid=1`), WAIT, or DROP.
  - Cleared by `reset`; wraps at 2^32.
- Undefined: port and counter absent; no other behaviour changes.

## Structure
- The shared package holds:
  - `ibus_req_t` and `ibus_resp_t`.
  - The FSM state enum `fd_ibuf_state_t`.
  - The `NOP_INSTR` default constant.
  - The slot struct `fd_slot_t` {`instr`, `pc`, `evector`, `valid`}.
- Sub-module `fd_slot_reg`: the decode register with flush/stall/load priority, used once. The hold register is a plain `fd_slot_t` flop.

## Test plan
- Zero-wait bus (`addr_ok`=`data_ok`=1 in the request cycle), PCs `0xbfc00000`, `+4`, `+8` → three consecutive `valid_d=1` slots with matching `pc_d`, one per cycle.
- `data_ok` 3 cycles after `addr_ok` with `stall_d=1` for 5 cycles → HOLD entered. Instruction appears one cycle after `stall_d` falls; exactly one `advance_f` pulse.
- `flush_d` in WAIT, then `data_ok` (`data=0x12345678`) two cycles later → `0x12345678` never appears on `instr_d`; `valid_d=0`; new request issued the cycle after the discarded `data_ok`.
- `pc_f=0xbfc00002` (`evector_f=8'h02`) → `ireq.valid` stays 0; slot delivered with `instr_d=NOP_INSTR`, `evector_d=8'h02`, `pc_d=0xbfc00002`.
- `flush_d` and `stall_d` together while in HOLD → slot discarded, `valid_d=0` next cycle, state REQ.
- With `FD_IBUF_STAT_EN`: 2-cycle `addr_ok` delay plus 3-cycle `data_ok` delay → `stat_wait_cycles` increases by 5.
